// File: rtl/axi4_slave_pkg.sv
// Shared types and constants for the AXI4 slave write path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi4_slave_pkg;

    // Widths of the stored burst descriptor fields
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_LEN_W  = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_LEN_W-1:0]  len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } aw_desc_t;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats
    function automatic logic is_wrap_len(input logic [31:0] beats_m1);
        return (beats_m1 == 32'd1) || (beats_m1 == 32'd3) ||
               (beats_m1 == 32'd7) || (beats_m1 == 32'd15);
    endfunction

endpackage

// File: rtl/axi4_slave_write_data_if.sv
// Descriptor, W, B and memory-port signals of the slave write-data engine.
// Latency: n/a (wiring only).
// Backpressure: W via wvalid/wready, B via bvalid/bready, descriptor gated by w_idle.
interface axi4_slave_write_data_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int BURST_LENGTH = 8
);
    // Descriptor handoff from the write-address stage
    logic                      aw_start;
    logic [ADDR_WIDTH-1:0]     stored_awaddr;
    logic [ID_WIDTH-1:0]       stored_awid;
    logic [BURST_LENGTH-1:0]   stored_awlen;
    logic [2:0]                stored_awsize;
    logic [1:0]                stored_awburst;
    logic                      w_idle;

    // W channel
    logic                      wvalid;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;
    logic                      wready;

    // Memory write port
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_wstrb;

    // B channel
    logic                      bvalid;
    logic                      bready;
    logic [ID_WIDTH-1:0]       bid;
    logic [1:0]                bresp;

    modport master (
        output aw_start, stored_awaddr, stored_awid, stored_awlen, stored_awsize, stored_awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        input  w_idle, wready, mem_we, mem_addr, mem_wdata, mem_wstrb, bvalid, bid, bresp
    );

    modport slave (
        input  aw_start, stored_awaddr, stored_awid, stored_awlen, stored_awsize, stored_awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        output w_idle, wready, mem_we, mem_addr, mem_wdata, mem_wstrb, bvalid, bid, bresp
    );

endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat address for FIXED / INCR / WRAP bursts; shared with the read-address stage.
// Latency: combinational.
// Backpressure: none; caller decides when to advance.
module axi4_burst_addr_gen
    import axi4_slave_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int BURST_LENGTH = 8
) (
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [2:0]              i_size,
    input  logic [BURST_LENGTH-1:0] i_len,
    input  logic [1:0]              i_burst,
    input  logic                    i_wrap_ok,
    output logic [ADDR_WIDTH-1:0]   o_next_addr
);

    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_aligned;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_seq;
    logic [ADDR_WIDTH-1:0] w_wrap_bytes;
    logic [ADDR_WIDTH-1:0] w_lower;

    assign w_bytes      = ADDR_WIDTH'(1) << i_size;
    // INCR realigns after the first beat, so an unaligned start only affects beat 0
    assign w_aligned    = i_addr & ~(w_bytes - ADDR_WIDTH'(1));
    assign w_incr       = w_aligned + w_bytes;
    // WRAP walks sequentially inside a window of (len+1)*bytes
    assign w_seq        = i_addr + w_bytes;
    assign w_wrap_bytes = (ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size;
    assign w_lower      = i_addr & ~(w_wrap_bytes - ADDR_WIDTH'(1));

    // Select the addressing mode; an illegal WRAP falls back to INCR
    always_comb begin
        o_next_addr = w_incr;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_WRAP: begin
                if (i_wrap_ok) begin
                    o_next_addr = (w_seq == (w_lower + w_wrap_bytes)) ? w_lower : w_seq;
                end
            end
            default: o_next_addr = w_incr;
        endcase
    end

endmodule

// File: rtl/axi4_slave_write_data.sv
// Slave W+B engine: one registered memory write per W beat, then one B response per burst.
// Latency: aw_start->wready 1 cycle, beat->mem_we 1 cycle, last beat->bvalid 1 cycle, bready->w_idle 1 cycle.
// Backpressure: wready only in W_DATA; bvalid/bid/bresp held until bready; aw_start ignored unless w_idle.
module axi4_slave_write_data
    import axi4_slave_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int BURST_LENGTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    axi4_slave_write_data_if.slave  bus
);

    // Largest beat size the data bus can carry, as log2(bytes)
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));

    w_state_t                  r_state;
    w_state_t                  w_state_nxt;
    aw_desc_t                  r_desc;
    logic [BURST_LENGTH:0]     r_beat_cnt;
    logic                      r_err;
    logic                      r_wrap_ok;
    logic                      r_no_write;

    logic                      r_mem_we;
    logic [ADDR_WIDTH-1:0]     r_mem_addr;
    logic [DATA_WIDTH-1:0]     r_mem_wdata;
    logic [DATA_WIDTH/8-1:0]   r_mem_wstrb;
    logic [ID_WIDTH-1:0]       r_bid;
    logic [1:0]                r_bresp;

    logic [ADDR_WIDTH-1:0]     w_cur_addr;
    logic [ADDR_WIDTH-1:0]     w_next_addr;
    logic [BURST_LENGTH-1:0]   w_cur_len;
    logic [ADDR_WIDTH-1:0]     w_start_mask;
    logic                      w_start_aligned;
    logic                      w_start_wrap_ok;
    logic                      w_start_no_write;
    logic                      w_start_err;
    logic                      w_accept_aw;
    logic                      w_beat;
    logic                      w_final_beat;
    logic                      w_frame_err;
    logic                      w_idle_c;
    logic                      w_wready_c;
    logic                      w_bvalid_c;

    // The running beat address lives in the descriptor's addr field
    assign w_cur_addr = ADDR_WIDTH'(r_desc.addr);
    assign w_cur_len  = BURST_LENGTH'(r_desc.len);

    // Descriptor qualification, evaluated once when the burst is taken
    assign w_start_mask     = (ADDR_WIDTH'(1) << bus.stored_awsize) - ADDR_WIDTH'(1);
    assign w_start_aligned  = (bus.stored_awaddr & w_start_mask) == '0;
    assign w_start_wrap_ok  = (bus.stored_awburst == BURST_WRAP) &&
                              is_wrap_len(32'(bus.stored_awlen)) && w_start_aligned;
    assign w_start_no_write = (bus.stored_awburst == BURST_RSVD) || (bus.stored_awsize > MAX_SIZE);
    assign w_start_err      = w_start_no_write ||
                              ((bus.stored_awburst == BURST_WRAP) && !w_start_wrap_ok);

    assign w_accept_aw  = (r_state == W_IDLE) && bus.aw_start;
    assign w_beat       = bus.wvalid && (r_state == W_DATA);
    // The beat counter, not wlast, decides where the burst ends
    assign w_final_beat = w_beat && (r_beat_cnt == {1'b0, w_cur_len});
    // wlast must be set on the final beat and only there
    assign w_frame_err  = w_beat && (w_final_beat ? !bus.wlast : bus.wlast);

    axi4_burst_addr_gen #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BURST_LENGTH (BURST_LENGTH)
    ) u_addr_gen (
        .i_addr      (w_cur_addr),
        .i_size      (r_desc.size),
        .i_len       (w_cur_len),
        .i_burst     (r_desc.burst),
        .i_wrap_ok   (r_wrap_ok),
        .o_next_addr (w_next_addr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= W_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the state-decoded handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_idle_c    = 1'b0;
        w_wready_c  = 1'b0;
        w_bvalid_c  = 1'b0;
        case (r_state)
            W_IDLE: begin
                w_idle_c = 1'b1;
                if (bus.aw_start) begin
                    w_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                w_wready_c = 1'b1;
                if (w_final_beat) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                w_bvalid_c = 1'b1;
                if (bus.bready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Latch the descriptor on start, then advance address, beat count and error per beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_desc     <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_wrap_ok  <= 1'b0;
            r_no_write <= 1'b0;
        end else if (w_accept_aw) begin
            r_desc.addr  <= AXI_ADDR_W'(bus.stored_awaddr);
            r_desc.id    <= AXI_ID_W'(bus.stored_awid);
            r_desc.len   <= AXI_LEN_W'(bus.stored_awlen);
            r_desc.size  <= bus.stored_awsize;
            r_desc.burst <= bus.stored_awburst;
            r_beat_cnt   <= '0;
            r_err        <= w_start_err;
            r_wrap_ok    <= w_start_wrap_ok;
            r_no_write   <= w_start_no_write;
        end else if (w_beat) begin
            r_desc.addr <= AXI_ADDR_W'(w_next_addr);
            r_beat_cnt  <= r_beat_cnt + (BURST_LENGTH+1)'(1);
            r_err       <= r_err | w_frame_err;
        end
    end

    // Registered memory write, one cycle after each accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_mem_we <= w_beat && !r_no_write;
            if (w_beat) begin
                r_mem_addr  <= w_cur_addr;
                r_mem_wdata <= bus.wdata;
                r_mem_wstrb <= bus.wstrb;
            end
        end
    end

    // Capture the response on the final beat so it is stable for the whole W_RESP phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bid   <= '0;
            r_bresp <= RESP_OKAY;
        end else if (w_final_beat) begin
            r_bid   <= ID_WIDTH'(r_desc.id);
            r_bresp <= (r_err || w_frame_err) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign bus.w_idle    = w_idle_c;
    assign bus.wready    = w_wready_c;
    assign bus.bvalid    = w_bvalid_c;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign bus.bid       = r_bid;
    assign bus.bresp     = r_bresp;

endmodule

// File: tb/tb_axi4_slave_write_data.sv
`timescale 1ns/1ps
module tb_axi4_slave_write_data;
    import axi4_slave_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_slave_write_data_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .BURST_LENGTH(8)) bus ();

    axi4_slave_write_data #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .BURST_LENGTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    int          checks    = 0;
    int          failures  = 0;
    int          resp_seen = 0;
    bit          chk_en    = 0;
    bit          b_pending = 0;
    logic [3:0]  exp_bid;
    logic [1:0]  exp_bresp;
    logic [3:0]  last_bid;
    logic [1:0]  last_bresp;
    wr_t         exp_q[$];
    logic [31:0] cap_addr[$];

    logic [31:0] t1_addr[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] t2_addr[4] = '{32'h38, 32'h3C, 32'h30, 32'h34};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_wrap_ok(input logic [31:0] a, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] bytes;
        bytes = 32'd1 << size;
        return (burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15) &&
               ((a % bytes) == 0);
    endfunction

    function automatic bit m_no_write(input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b11) || (size > 3'd2);
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst,
                                               input int n);
        logic [31:0] bytes, wb, lower;
        bytes = 32'd1 << size;
        if (burst == 2'b00) return a;
        if (m_wrap_ok(a, len, size, burst)) begin
            wb    = (32'(len) + 1) * bytes;
            lower = a - (a % wb);
            return lower + (((a - lower) + 32'(n) * bytes) % wb);
        end
        if (n == 0) return a;
        return (a - (a % bytes)) + 32'(n) * bytes;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input int early, input bit nolast);
        bit err;
        err = m_no_write(burst, size) ||
              (burst == 2'b10 && !m_wrap_ok(a, len, size, burst)) ||
              (early >= 0 && early < int'(len)) || nolast;
        return err ? 2'b10 : 2'b00;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_we: addr 0x%0h with no beat outstanding", bus.mem_addr);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
                    check("mem_wdata", 64'(bus.mem_wdata), 64'(e.data));
                    check("mem_wstrb", 64'(bus.mem_wstrb), 64'(e.strb));
                    cap_addr.push_back(bus.mem_addr);
                end
            end
            if (bus.bvalid === 1'b1) begin
                if (!b_pending) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bvalid: bid 0x%0h bresp 0x%0h", bus.bid, bus.bresp);
                end else begin
                    check("bid", 64'(bus.bid), 64'(exp_bid));
                    check("bresp", 64'(bus.bresp), 64'(exp_bresp));
                    if (bus.bready) begin
                        b_pending  = 0;
                        last_bid   = bus.bid;
                        last_bresp = bus.bresp;
                        resp_seen++;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_w_idle"}, 64'(bus.w_idle), 64'd1);
        check({tag, "_wready"}, 64'(bus.wready), 64'd0);
        check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
        check({tag, "_bvalid"}, 64'(bus.bvalid), 64'd0);
        check({tag, "_bid"}, 64'(bus.bid), 64'd0);
        check({tag, "_bresp"}, 64'(bus.bresp), 64'd0);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, "_mem_wstrb"}, 64'(bus.mem_wstrb), 64'd0);
    endtask

    // ---------------- burst driver ----------------
    task automatic run_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int early,
                             input bit nolast, input int bdelay, input int gap_pct,
                             input int abort_after, input bit inject_aw, input logic [31:0] data_base);
        int t;
        int rs0;
        bit nw;
        bit gapped;
        wr_t e;
        nw = m_no_write(burst, size);
        t = 0;
        smp();
        while (!bus.w_idle && t < 100) begin smp(); t++; end
        if (!bus.w_idle) begin timeout("idle_wait"); return; end
        rs0 = resp_seen;
        @(posedge clk); #1;
        b_pending = 1;
        exp_bid   = id;
        exp_bresp = model_resp(a, len, size, burst, early, nolast);
        bus.aw_start       = 1'b1;
        bus.stored_awaddr  = a;
        bus.stored_awid    = id;
        bus.stored_awlen   = len;
        bus.stored_awsize  = size;
        bus.stored_awburst = burst;
        bus.bready         = (bdelay == 0);
        @(posedge clk); #1;
        bus.aw_start       = 1'b0;
        bus.stored_awaddr  = $urandom;
        bus.stored_awid    = 4'($urandom);
        bus.stored_awlen   = 8'($urandom);
        bus.stored_awsize  = 3'($urandom);
        bus.stored_awburst = 2'($urandom);
        for (int n = 0; n <= int'(len); n++) begin
            gapped = 0;
            while ($urandom_range(99) < gap_pct) begin
                bus.wvalid = 1'b0;
                gapped = 1;
                @(posedge clk); #1;
            end
            bus.wvalid = 1'b1;
            bus.wdata  = (data_base != 0) ? data_base + 32'(n) : $urandom;
            bus.wstrb  = 4'($urandom);
            bus.wlast  = (n == early) || (n == int'(len) && !nolast);
            t = 0;
            smp();
            while (!bus.wready && t < 20) begin smp(); t++; end
            if (!bus.wready) begin timeout("wready_wait"); bus.wvalid = 1'b0; return; end
            if (n == 0 && !gapped) begin
                check("aw_to_wready_cycles", 64'(t), 64'd0);
            end
            if (!nw) begin
                e.addr = model_addr(a, len, size, burst, n);
                e.data = bus.wdata;
                e.strb = bus.wstrb;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            bus.wvalid = 1'b0;
            bus.wlast  = 1'b0;
            if (n == abort_after) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                b_pending  = 0;
                bus.bready = 1'b0;
                smp();
                check_reset_outputs("abort");
                check("abort_writes_drained", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
                return;
            end
        end
        smp();
        check("last_to_bvalid", 64'(bus.bvalid), 64'd1);
        check("wready_after_last", 64'(bus.wready), 64'd0);
        if (bdelay > 0) begin
            for (int d = 0; d < bdelay; d++) begin
                @(posedge clk); #1;
                bus.aw_start = inject_aw && (d == 1);
                check("bvalid_held", 64'(bus.bvalid), 64'd1);
            end
            bus.aw_start = 1'b0;
            bus.bready   = 1'b1;
        end
        t = 0;
        while (resp_seen == rs0 && t < 50) begin smp(); t++; end
        if (resp_seen == rs0) begin
            timeout("bresp_wait");
        end else begin
            smp();
            check("idle_after_bready", 64'(bus.w_idle), 64'd1);
            check("bvalid_dropped", 64'(bus.bvalid), 64'd0);
        end
        bus.bready = 1'b0;
        check("writes_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_caps(input string nm, input logic [31:0] req[4]);
        check({nm, "_count"}, 64'(cap_addr.size()), 64'd4);
        if (cap_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) check({nm, "_addr"}, 64'(cap_addr[i]), 64'(req[i]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst                = 1'b1;
        bus.aw_start       = 1'b0;
        bus.stored_awaddr  = '0;
        bus.stored_awid    = '0;
        bus.stored_awlen   = '0;
        bus.stored_awsize  = '0;
        bus.stored_awburst = '0;
        bus.wvalid         = 1'b0;
        bus.wdata          = '0;
        bus.wstrb          = '0;
        bus.wlast          = 1'b0;
        bus.bready         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        smp();
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst    = 1'b0;
        chk_en = 1;

        // Hand-computed pins for the model
        check("model_wrap_beat2", 64'(model_addr(32'h38, 8'd3, 3'd2, BURST_WRAP, 2)), 64'h30);
        check("model_incr_unaligned", 64'(model_addr(32'h103, 8'd3, 3'd2, BURST_INCR, 3)), 64'h10C);
        check("model_badwrap_resp", 64'(model_resp(32'h40, 8'd2, 3'd2, BURST_WRAP, -1, 0)), 64'h2);

        // INCR
        cap_addr.delete();
        run_burst(32'h100, 4'h5, 8'd3, 3'd2, BURST_INCR, -1, 0, 0, 0, -1, 0, 32'hA0);
        check_caps("t1", t1_addr);
        check("t1_bresp", 64'(last_bresp), 64'h0);
        check("t1_bid", 64'(last_bid), 64'h5);

        // WRAP
        cap_addr.delete();
        run_burst(32'h38, 4'h9, 8'd3, 3'd2, BURST_WRAP, -1, 0, 1, 0, -1, 0, 32'h0);
        check_caps("t2", t2_addr);
        check("t2_bresp", 64'(last_bresp), 64'h0);

        // FIXED
        cap_addr.delete();
        run_burst(32'h20, 4'h3, 8'd2, 3'd2, BURST_FIXED, -1, 0, 2, 30, -1, 0, 32'h0);
        check("t3_count", 64'(cap_addr.size()), 64'd3);
        for (int i = 0; i < cap_addr.size(); i++) check("t3_addr", 64'(cap_addr[i]), 64'h20);
        check("t3_bresp", 64'(last_bresp), 64'h0);

        // Early wlast, then missing wlast on a single-beat burst
        cap_addr.delete();
        run_burst(32'h200, 4'h1, 8'd3, 3'd2, BURST_INCR, 1, 0, 0, 0, -1, 0, 32'h0);
        check("t4a_count", 64'(cap_addr.size()), 64'd4);
        check("t4a_bresp", 64'(last_bresp), 64'h2);
        cap_addr.delete();
        run_burst(32'h300, 4'h2, 8'd0, 3'd2, BURST_INCR, -1, 1, 0, 0, -1, 0, 32'h0);
        check("t4b_count", 64'(cap_addr.size()), 64'd1);
        check("t4b_bresp", 64'(last_bresp), 64'h2);

        // Response stall with a stray aw_start
        cap_addr.delete();
        run_burst(32'h400, 4'hC, 8'd1, 3'd2, BURST_INCR, -1, 0, 5, 0, -1, 1, 32'h0);
        check("t5_count", 64'(cap_addr.size()), 64'd2);
        check("t5_bresp", 64'(last_bresp), 64'h0);
        check("t5_bid", 64'(last_bid), 64'hC);

        // Reserved burst: accepted, nothing written
        cap_addr.delete();
        run_burst(32'h480, 4'h4, 8'd2, 3'd2, BURST_RSVD, -1, 0, 0, 0, -1, 0, 32'h0);
        check("rsvd_count", 64'(cap_addr.size()), 64'd0);
        check("rsvd_bresp", 64'(last_bresp), 64'h2);

        // Reset mid-burst, then a clean burst
        cap_addr.delete();
        run_burst(32'h500, 4'h7, 8'd7, 3'd2, BURST_INCR, -1, 0, 0, 0, 1, 0, 32'h0);
        check("t6_abort_count", 64'(cap_addr.size()), 64'd2);
        cap_addr.delete();
        run_burst(32'h600, 4'h6, 8'd2, 3'd2, BURST_INCR, -1, 0, 1, 0, -1, 0, 32'h0);
        check("t6_after_count", 64'(cap_addr.size()), 64'd3);
        check("t6_after_bresp", 64'(last_bresp), 64'h0);
        check("t6_after_bid", 64'(last_bid), 64'h6);

        // Randomized bursts
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic [7:0]  len;
            logic [2:0]  size;
            logic [1:0]  burst;
            int          early;
            bit          nolast;
            int          r;
            r = $urandom_range(0, 9);
            burst = (r < 3) ? BURST_INCR : (r < 7) ? BURST_WRAP : (r < 9) ? BURST_FIXED : BURST_RSVD;
            size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (burst == BURST_WRAP && $urandom_range(0, 9) < 7) begin
                r   = $urandom_range(0, 3);
                len = (r == 0) ? 8'd1 : (r == 1) ? 8'd3 : (r == 2) ? 8'd7 : 8'd15;
            end else begin
                len = 8'($urandom_range(0, 15));
            end
            a = $urandom;
            if ($urandom_range(0, 9) < 6) a = a & ~((32'd1 << size) - 32'd1);
            early = -1;
            if (len > 0 && $urandom_range(0, 9) < 2) early = $urandom_range(0, int'(len) - 1);
            nolast = ($urandom_range(0, 9) == 0);
            run_burst(a, 4'($urandom), len, size, burst, early, nolast,
                      $urandom_range(0, 3), 30, -1, 0, 32'h0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
